// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with the EX-side operand logic that feeds the 32-bit ALU:
// ALU control decode, immediate extension, EX/MEM and MEM/WB forwarding, and
// destination/write-enable selection for write-back.
module id_ex_operand_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_rs_data,
  input  logic [XLEN-1:0] id_rt_data,
  input  logic [15:0]     id_imm16,
  input  logic [4:0]      id_rs,
  input  logic [4:0]      id_rt,
  input  logic [4:0]      id_rd,
  input  logic [1:0]      id_alu_op,
  input  logic [5:0]      id_funct,
  input  logic            id_alu_src,
  input  logic            id_reg_dst,
  input  logic            id_reg_write,
  input  logic            exmem_reg_write,
  input  logic [4:0]      exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [4:0]      memwb_rd,
  input  logic [XLEN-1:0] memwb_data,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctl,
  output logic [XLEN-1:0] ex_store_data,
  output logic [4:0]      ex_dst,
  output logic            ex_reg_write,
  output logic            ex_valid,
  output logic            ex_illegal
);

  // ID/EX pipeline fields
  logic            valid_r;
  logic [XLEN-1:0] rs_data_r;
  logic [XLEN-1:0] rt_data_r;
  logic [15:0]     imm_r;
  logic [4:0]      rs_r;
  logic [4:0]      rt_r;
  logic [4:0]      rd_r;
  logic [1:0]      alu_op_r;
  logic [5:0]      funct_r;
  logic            alu_src_r;
  logic            reg_dst_r;
  logic            reg_write_r;

  // EX-side combinational values
  logic [XLEN-1:0] fwd_rs_s;
  logic [XLEN-1:0] fwd_rt_s;
  logic [XLEN-1:0] imm_ext_s;
  logic            funct_ok_s;

  // Pipeline register: reset and flush both load an all-zero bubble, stall holds
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_r     <= 1'b0;
      rs_data_r   <= {XLEN{1'b0}};
      rt_data_r   <= {XLEN{1'b0}};
      imm_r       <= 16'd0;
      rs_r        <= 5'd0;
      rt_r        <= 5'd0;
      rd_r        <= 5'd0;
      alu_op_r    <= 2'b00;
      funct_r     <= 6'd0;
      alu_src_r   <= 1'b0;
      reg_dst_r   <= 1'b0;
      reg_write_r <= 1'b0;
    end else if (!stall) begin
      valid_r     <= id_valid;
      rs_data_r   <= id_rs_data;
      rt_data_r   <= id_rt_data;
      imm_r       <= id_imm16;
      rs_r        <= id_rs;
      rt_r        <= id_rt;
      rd_r        <= id_rd;
      alu_op_r    <= id_alu_op;
      funct_r     <= id_funct;
      alu_src_r   <= id_alu_src;
      reg_dst_r   <= id_reg_dst;
      reg_write_r <= id_reg_write;
    end
  end

  // ALU control decode from the registered ALUOp/funct; unknown R-type funct defaults to ADD
  always_comb begin
    alu_ctl    = 4'b0010;
    funct_ok_s = 1'b1;
    case (alu_op_r)
      2'b00: alu_ctl = 4'b0010;
      2'b01: alu_ctl = 4'b0110;
      2'b11: alu_ctl = 4'b0001;
      2'b10: begin
        case (funct_r)
          6'b100000: alu_ctl = 4'b0010;
          6'b100010: alu_ctl = 4'b0110;
          6'b100100: alu_ctl = 4'b0000;
          6'b100101: alu_ctl = 4'b0001;
          6'b100111: alu_ctl = 4'b1100;
          6'b101010: alu_ctl = 4'b0111;
          default: begin
            alu_ctl    = 4'b0010;
            funct_ok_s = 1'b0;
          end
        endcase
      end
      default: alu_ctl = 4'b0010;
    endcase
  end

  // Forwarding for rs: EX/MEM beats MEM/WB, and $0 is never forwarded
  always_comb begin
    fwd_rs_s = rs_data_r;
    if ((rs_r != 5'd0) && exmem_reg_write && (exmem_rd == rs_r)) begin
      fwd_rs_s = exmem_result;
    end else if ((rs_r != 5'd0) && memwb_reg_write && (memwb_rd == rs_r)) begin
      fwd_rs_s = memwb_data;
    end else begin
      fwd_rs_s = rs_data_r;
    end
  end

  // Forwarding for rt, shared by the b operand and the store data path
  always_comb begin
    fwd_rt_s = rt_data_r;
    if ((rt_r != 5'd0) && exmem_reg_write && (exmem_rd == rt_r)) begin
      fwd_rt_s = exmem_result;
    end else if ((rt_r != 5'd0) && memwb_reg_write && (memwb_rd == rt_r)) begin
      fwd_rt_s = memwb_data;
    end else begin
      fwd_rt_s = rt_data_r;
    end
  end

  // Operand selection and write-back control; OR-immediate zero-extends, all else sign-extends
  always_comb begin
    if (alu_op_r == 2'b11) begin
      imm_ext_s = {{(XLEN-16){1'b0}}, imm_r};
    end else begin
      imm_ext_s = {{(XLEN-16){imm_r[15]}}, imm_r};
    end
    alu_a         = fwd_rs_s;
    alu_b         = alu_src_r ? imm_ext_s : fwd_rt_s;
    ex_store_data = fwd_rt_s;
    ex_dst        = reg_dst_r ? rd_r : rt_r;
    ex_valid      = valid_r;
    ex_illegal    = valid_r & ~funct_ok_s;
    ex_reg_write  = valid_r & reg_write_r & funct_ok_s;
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed vector table, hand-written
// reset/stall/flush sequences, and a randomized run against a reference model.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm16;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic        id_alu_src, id_reg_dst, id_reg_write;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_data;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_ctl;
  logic [4:0]  ex_dst;
  logic        ex_reg_write, ex_valid, ex_illegal;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm16(id_imm16),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_funct(id_funct), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_reg_write(id_reg_write), .exmem_reg_write(exmem_reg_write),
    .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl), .ex_store_data(ex_store_data),
    .ex_dst(ex_dst), .ex_reg_write(ex_reg_write), .ex_valid(ex_valid),
    .ex_illegal(ex_illegal)
  );

  typedef struct {
    logic        v;
    logic [1:0]  op;
    logic [5:0]  f;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd;
    logic [15:0] imm;
    logic        src, dst, w;
    logic        xw;
    logic [4:0]  xrd;
    logic [31:0] xres;
    logic        mw;
    logic [4:0]  mrd;
    logic [31:0] mdat;
    logic [31:0] ea, eb, es;
    logic [3:0]  ectl;
    logic [4:0]  edst;
    logic        erw, evalid, eill;
  } vec_t;

  vec_t tv [14];

  // Model state: the instruction fields currently held in the EX slot
  typedef struct {
    logic        v;
    logic [1:0]  op;
    logic [5:0]  f;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd;
    logic [15:0] imm;
    logic        src, dst, w;
  } slot_t;

  slot_t m;

  logic [5:0] fn_tab [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
  logic [3:0] ct_tab [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_vec(input vec_t t);
    id_valid = t.v; id_alu_op = t.op; id_funct = t.f;
    id_rs = t.rs; id_rt = t.rt; id_rd = t.rd;
    id_rs_data = t.rsd; id_rt_data = t.rtd; id_imm16 = t.imm;
    id_alu_src = t.src; id_reg_dst = t.dst; id_reg_write = t.w;
    exmem_reg_write = t.xw; exmem_rd = t.xrd; exmem_result = t.xres;
    memwb_reg_write = t.mw; memwb_rd = t.mrd; memwb_data = t.mdat;
  endtask

  task automatic rand_id();
    id_valid = 1'($urandom); id_alu_op = 2'($urandom);
    id_funct = ($urandom_range(0, 1) == 0) ? fn_tab[$urandom_range(0, 5)] : 6'($urandom);
    id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3)); id_rd = 5'($urandom);
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm16 = 16'($urandom);
    id_alu_src = 1'($urandom); id_reg_dst = 1'($urandom); id_reg_write = 1'($urandom);
  endtask

  // Value a source register sees: youngest writer in flight wins, $0 is hardwired
  function automatic logic [31:0] model_src(input logic [4:0] x, input logic [31:0] own);
    if (x == 5'd0) return own;
    if (exmem_reg_write && exmem_rd == x) return exmem_result;
    if (memwb_reg_write && memwb_rd == x) return memwb_data;
    return own;
  endfunction

  task automatic check_model();
    logic [3:0]  ectl;
    logic        known;
    logic [31:0] immx;
    ectl  = 4'b0010;
    known = 1'b1;
    if (m.op == 2'b01) ectl = 4'b0110;
    else if (m.op == 2'b11) ectl = 4'b0001;
    else if (m.op == 2'b10) begin
      known = 1'b0;
      for (int k = 0; k < 6; k++) begin
        if (fn_tab[k] == m.f) begin
          ectl  = ct_tab[k];
          known = 1'b1;
        end
      end
    end
    immx = (m.op == 2'b11) ? 32'(m.imm) : 32'(signed'(m.imm));
    chk("rnd_alu_a", alu_a, model_src(m.rs, m.rsd));
    chk("rnd_alu_b", alu_b, m.src ? immx : model_src(m.rt, m.rtd));
    chk("rnd_store", ex_store_data, model_src(m.rt, m.rtd));
    chk("rnd_ctl", 32'(alu_ctl), 32'(ectl));
    chk("rnd_dst", 32'(ex_dst), 32'(m.dst ? m.rd : m.rt));
    chk("rnd_valid", 32'(ex_valid), 32'(m.v));
    chk("rnd_illegal", 32'(ex_illegal), 32'(m.v && !known));
    chk("rnd_rw", 32'(ex_reg_write), 32'(m.v && m.w && known));
  endtask

  initial begin
    tv[0]  = '{1'b1, 2'b10, 6'b100111, 5'd5, 5'd6, 5'd9, 32'h0F0F0000, 32'h00FF0000, 16'h0000, 1'b0, 1'b1, 1'b1,
               1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
               32'h0F0F0000, 32'h00FF0000, 32'h00FF0000, 4'b1100, 5'd9, 1'b1, 1'b1, 1'b0};
    tv[1]  = '{1'b1, 2'b00, 6'd0, 5'd3, 5'd4, 5'd0, 32'hAAAA, 32'hBBBB, 16'h0000, 1'b0, 1'b0, 1'b1,
               1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22,
               32'h11, 32'hBBBB, 32'hBBBB, 4'b0010, 5'd4, 1'b1, 1'b1, 1'b0};
    tv[2]  = '{1'b1, 2'b00, 6'd0, 5'd3, 5'd4, 5'd0, 32'hAAAA, 32'hBBBB, 16'h0000, 1'b0, 1'b0, 1'b1,
               1'b0, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22,
               32'h22, 32'hBBBB, 32'hBBBB, 4'b0010, 5'd4, 1'b1, 1'b1, 1'b0};
    tv[3]  = '{1'b1, 2'b00, 6'd0, 5'd0, 5'd7, 5'd0, 32'h0, 32'h1234, 16'h0000, 1'b0, 1'b0, 1'b1,
               1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF,
               32'h0, 32'h1234, 32'h1234, 4'b0010, 5'd7, 1'b1, 1'b1, 1'b0};
    tv[4]  = '{1'b1, 2'b11, 6'd0, 5'd1, 5'd2, 5'd0, 32'h5, 32'h6, 16'h8001, 1'b1, 1'b0, 1'b1,
               1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
               32'h5, 32'h00008001, 32'h6, 4'b0001, 5'd2, 1'b1, 1'b1, 1'b0};
    tv[5]  = '{1'b1, 2'b00, 6'd0, 5'd1, 5'd2, 5'd0, 32'h5, 32'h6, 16'h8001, 1'b1, 1'b0, 1'b1,
               1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
               32'h5, 32'hFFFF8001, 32'h6, 4'b0010, 5'd2, 1'b1, 1'b1, 1'b0};
    tv[6]  = '{1'b1, 2'b10, 6'b111111, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 16'h0000, 1'b0, 1'b1, 1'b1,
               1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
               32'h5, 32'h6, 32'h6, 4'b0010, 5'd3, 1'b0, 1'b1, 1'b1};
    tv[7]  = '{1'b1, 2'b01, 6'd0, 5'd1, 5'd8, 5'd0, 32'h5, 32'h6, 16'h0000, 1'b0, 1'b0, 1'b1,
               1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h77,
               32'h5, 32'h77, 32'h77, 4'b0110, 5'd8, 1'b1, 1'b1, 1'b0};
    tv[8]  = '{1'b1, 2'b10, 6'b101010, 5'd1, 5'd8, 5'd10, 32'h5, 32'h6, 16'h0004, 1'b1, 1'b1, 1'b1,
               1'b1, 5'd8, 32'h99, 1'b0, 5'd0, 32'h0,
               32'h5, 32'h4, 32'h99, 4'b0111, 5'd10, 1'b1, 1'b1, 1'b0};
    tv[9]  = '{1'b1, 2'b10, 6'b100100, 5'd2, 5'd3, 5'd4, 32'hF0, 32'h3C, 16'h0000, 1'b0, 1'b1, 1'b1,
               1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
               32'hF0, 32'h3C, 32'h3C, 4'b0000, 5'd4, 1'b1, 1'b1, 1'b0};
    tv[10] = '{1'b0, 2'b10, 6'b111111, 5'd2, 5'd3, 5'd4, 32'hF0, 32'h3C, 16'h0000, 1'b0, 1'b1, 1'b1,
               1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
               32'hF0, 32'h3C, 32'h3C, 4'b0010, 5'd4, 1'b0, 1'b0, 1'b0};
    tv[11] = '{1'b1, 2'b10, 6'b100010, 5'd2, 5'd3, 5'd4, 32'h1, 32'h2, 16'h0000, 1'b0, 1'b1, 1'b0,
               1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
               32'h1, 32'h2, 32'h2, 4'b0110, 5'd4, 1'b0, 1'b1, 1'b0};
    tv[12] = '{1'b1, 2'b10, 6'b100101, 5'd2, 5'd3, 5'd4, 32'h1, 32'h2, 16'h0000, 1'b0, 1'b1, 1'b1,
               1'b0, 5'd2, 32'hEE, 1'b1, 5'd5, 32'hDD,
               32'h1, 32'h2, 32'h2, 4'b0001, 5'd4, 1'b1, 1'b1, 1'b0};
    tv[13] = '{1'b1, 2'b10, 6'b100000, 5'd2, 5'd3, 5'd4, 32'h1, 32'h2, 16'h0000, 1'b0, 1'b0, 1'b1,
               1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'hCC,
               32'hCC, 32'h2, 32'h2, 4'b0010, 5'd3, 1'b1, 1'b1, 1'b0};

    // Reset: two cycles with random ID inputs, no forwarding activity
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 32'h0;
    memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_data = 32'h0;
    for (int c = 0; c < 2; c++) begin
      rand_id();
      @(posedge clk); #1;
      chk("rst_valid", 32'(ex_valid), 32'h0);
      chk("rst_rw", 32'(ex_reg_write), 32'h0);
      chk("rst_illegal", 32'(ex_illegal), 32'h0);
      chk("rst_ctl", 32'(alu_ctl), 32'h2);
      chk("rst_dst", 32'(ex_dst), 32'h0);
      chk("rst_alu_a", alu_a, 32'h0);
      chk("rst_alu_b", alu_b, 32'h0);
    end
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      drive_vec(tv[i]);
      @(posedge clk); #1;
      chk($sformatf("v%0d_alu_a", i), alu_a, tv[i].ea);
      chk($sformatf("v%0d_alu_b", i), alu_b, tv[i].eb);
      chk($sformatf("v%0d_store", i), ex_store_data, tv[i].es);
      chk($sformatf("v%0d_ctl", i), 32'(alu_ctl), 32'(tv[i].ectl));
      chk($sformatf("v%0d_dst", i), 32'(ex_dst), 32'(tv[i].edst));
      chk($sformatf("v%0d_rw", i), 32'(ex_reg_write), 32'(tv[i].erw));
      chk($sformatf("v%0d_valid", i), 32'(ex_valid), 32'(tv[i].evalid));
      chk($sformatf("v%0d_illegal", i), 32'(ex_illegal), 32'(tv[i].eill));
    end

    // Stall: load the NOR instruction, then hold it for 3 cycles while ID changes
    drive_vec(tv[0]);
    @(posedge clk); #1;
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      rand_id();
      @(posedge clk); #1;
      chk("stall_alu_a", alu_a, 32'h0F0F0000);
      chk("stall_alu_b", alu_b, 32'h00FF0000);
      chk("stall_ctl", 32'(alu_ctl), 32'hC);
      chk("stall_dst", 32'(ex_dst), 32'd9);
      chk("stall_valid", 32'(ex_valid), 32'h1);
      chk("stall_rw", 32'(ex_reg_write), 32'h1);
    end
    // A producer appearing while stalled must be picked up
    exmem_reg_write = 1'b1; exmem_rd = 5'd5; exmem_result = 32'h55;
    @(posedge clk); #1;
    chk("stall_fwd_a", alu_a, 32'h55);
    // Flush wins over stall
    flush = 1'b1; id_valid = 1'b1; id_reg_write = 1'b1;
    @(posedge clk); #1;
    chk("flush_valid", 32'(ex_valid), 32'h0);
    chk("flush_rw", 32'(ex_reg_write), 32'h0);
    chk("flush_illegal", 32'(ex_illegal), 32'h0);
    chk("flush_dst", 32'(ex_dst), 32'h0);
    flush = 1'b0; stall = 1'b0;

    // Randomized run against the reference model; starts from reset to sync the model
    for (int c = 0; c < 400; c++) begin
      rand_id();
      rst   = (c == 0) || ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 4) == 0);
      exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3)); exmem_result = $urandom;
      memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3)); memwb_data = $urandom;
      @(posedge clk);
      if (rst || flush) begin
        m = '{v: 1'b0, op: 2'b00, f: 6'd0, rs: 5'd0, rt: 5'd0, rd: 5'd0, rsd: 32'h0, rtd: 32'h0,
              imm: 16'h0, src: 1'b0, dst: 1'b0, w: 1'b0};
      end else if (!stall) begin
        m = '{v: id_valid, op: id_alu_op, f: id_funct, rs: id_rs, rt: id_rt, rd: id_rd,
              rsd: id_rs_data, rtd: id_rt_data, imm: id_imm16, src: id_alu_src,
              dst: id_reg_dst, w: id_reg_write};
      end
      #1;
      check_model();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
